// File: rtl/ml_multi_interface_if.sv
// Bundle between the multi-channel readout front end and its environment:
// per-channel capture strobes and data, inference-engine handshake, tagged results.
interface ml_multi_interface_if #(
  parameter int N_CH  = 4,
  parameter int IN_W  = 32,
  parameter int OUT_W = 18
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]        start_trigger;
  logic [N_CH*2*IN_W-1:0] accumulated_data;
  logic                   nn_start;
  logic [2*OUT_W-1:0]     nn_input;
  logic                   nn_done;
  logic [OUT_W-1:0]       nn_prob;
  logic                   nn_state;
  logic                   result_valid;
  logic [CH_W-1:0]        result_channel;
  logic [OUT_W-1:0]       inference_prob;
  logic                   inference_state;
  logic                   result_timeout;
  logic [N_CH-1:0]        overrun;
  logic                   busy;

  modport master (
    input  start_trigger, accumulated_data, nn_done, nn_prob, nn_state,
    output nn_start, nn_input, result_valid, result_channel, inference_prob,
           inference_state, result_timeout, overrun, busy
  );

  modport slave (
    output start_trigger, accumulated_data, nn_done, nn_prob, nn_state,
    input  nn_start, nn_input, result_valid, result_channel, inference_prob,
           inference_state, result_timeout, overrun, busy
  );
endinterface

// File: rtl/ml_multi_interface.sv
// Multi-channel readout front end: capture, shift+saturate, round-robin onto one
// inference engine, channel-tagged results with overrun flags and engine watchdog.
module ml_multi_interface #(
  parameter int N_CH    = 4,
  parameter int IN_W    = 32,
  parameter int OUT_W   = 18,
  parameter int SHIFT   = 14,
  parameter int TIMEOUT = 1023
) (
  input logic                  clk,
  input logic                  rst,
  ml_multi_interface_if.master io_bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_START, S_WAIT} state_t;

  state_t             r_state;
  logic [N_CH-1:0]    r_pending;
  logic [N_CH-1:0]    r_overrun;
  logic [2*IN_W-1:0]  r_cap [N_CH];
  logic [2*IN_W-1:0]  r_job;
  logic [CH_W-1:0]    r_ptr;
  logic [CH_W-1:0]    r_sel;
  logic [TO_W-1:0]    r_cnt;
  logic               r_nn_start;
  logic [2*OUT_W-1:0] r_nn_input;
  logic               r_result_valid;
  logic [CH_W-1:0]    r_res_ch;
  logic [OUT_W-1:0]   r_inf_prob;
  logic               r_inf_state;
  logic               r_timeout;

  logic               w_found;
  logic               w_grant;
  logic [CH_W-1:0]    w_pick;
  logic [CH_W-1:0]    w_idx;
  logic [N_CH-1:0]    w_grant_vec;

  function automatic logic [OUT_W-1:0] sat(input logic signed [IN_W-1:0] x);
    logic signed [IN_W-1:0] s;
    s = x >>> SHIFT;
    if ((&s[IN_W-1:OUT_W-1]) || !(|s[IN_W-1:OUT_W-1]))
      sat = s[OUT_W-1:0];
    else if (s[IN_W-1])
      sat = {1'b1, {(OUT_W-1){1'b0}}};
    else
      sat = {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  // First pending channel at or after the pointer, wrapping at N_CH.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_idx = CH_W'((int'(r_ptr) + i) % N_CH);
      if (!w_found && r_pending[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_grant     = (r_state == S_IDLE) && w_found;
    w_grant_vec = '0;
    if (w_grant) w_grant_vec[w_pick] = 1'b1;
  end

  // A trigger landing on the channel being granted refills it instead of overrunning.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_overrun <= '0;
      for (int k = 0; k < N_CH; k++) r_cap[k] <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (io_bus.start_trigger[k]) begin
          if (r_pending[k] && !w_grant_vec[k]) begin
            r_overrun[k] <= 1'b1;
          end else begin
            r_cap[k]     <= io_bus.accumulated_data[k*2*IN_W +: 2*IN_W];
            r_pending[k] <= 1'b1;
          end
        end else if (w_grant_vec[k]) begin
          r_pending[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_ptr          <= '0;
      r_sel          <= '0;
      r_job          <= '0;
      r_cnt          <= '0;
      r_nn_start     <= 1'b0;
      r_nn_input     <= '0;
      r_result_valid <= 1'b0;
      r_res_ch       <= '0;
      r_inf_prob     <= '0;
      r_inf_state    <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_nn_start     <= 1'b0;
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_sel   <= w_pick;
            r_job   <= r_cap[w_pick];
            r_ptr   <= (w_pick == LAST_CH) ? '0 : w_pick + 1'b1;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          r_nn_input <= {sat(r_job[2*IN_W-1:IN_W]), sat(r_job[IN_W-1:0])};
          r_nn_start <= 1'b1;
          r_state    <= S_START;
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (io_bus.nn_done) begin
            r_inf_prob     <= io_bus.nn_prob;
            r_inf_state    <= io_bus.nn_state;
            r_res_ch       <= r_sel;
            r_timeout      <= 1'b0;
            r_result_valid <= 1'b1;
            r_state        <= S_IDLE;
          end else if (r_cnt == TO_LAST) begin
            r_inf_prob     <= '0;
            r_inf_state    <= 1'b0;
            r_res_ch       <= r_sel;
            r_timeout      <= 1'b1;
            r_result_valid <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.nn_start        = r_nn_start;
  assign io_bus.nn_input        = r_nn_input;
  assign io_bus.result_valid    = r_result_valid;
  assign io_bus.result_channel  = r_res_ch;
  assign io_bus.inference_prob  = r_inf_prob;
  assign io_bus.inference_state = r_inf_state;
  assign io_bus.result_timeout  = r_timeout;
  assign io_bus.overrun         = r_overrun;
  assign io_bus.busy            = (r_state != S_IDLE) || (|r_pending);
endmodule

// File: tb/tb_ml_multi_interface.sv
// Scoreboard bench: two front ends (SHIFT=14/TIMEOUT=1023 and SHIFT=0/TIMEOUT=20)
// driven with directed vectors; a per-instance engine model answers nn_start.
module tb_ml_multi_interface;
  logic clk = 1'b0;
  logic rst_0, rst_1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int ch; logic [17:0] prob; logic st; logic to; int cyc; } res_t;
  typedef struct { logic [35:0] inp; int cyc; } inp_t;
  typedef struct { logic reply; int dly; logic [17:0] prob; logic st; } eng_t;

  res_t er0[$], er1[$];
  inp_t ei0[$], ei1[$];
  eng_t eq0[$], eq1[$];

  ml_multi_interface_if #(.N_CH(4), .IN_W(32), .OUT_W(18)) bus_0 ();
  ml_multi_interface_if #(.N_CH(4), .IN_W(32), .OUT_W(18)) bus_1 ();

  ml_multi_interface #(.N_CH(4), .IN_W(32), .OUT_W(18), .SHIFT(14), .TIMEOUT(1023))
    dut_0 (.clk(clk), .rst(rst_0), .io_bus(bus_0.master));
  ml_multi_interface #(.N_CH(4), .IN_W(32), .OUT_W(18), .SHIFT(0), .TIMEOUT(20))
    dut_1 (.clk(clk), .rst(rst_1), .io_bus(bus_1.master));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set0(input int k, input logic [31:0] i_v, input logic [31:0] q_v);
    bus_0.accumulated_data[k*64 +: 64] = {q_v, i_v};
  endtask

  task automatic set1(input int k, input logic [31:0] i_v, input logic [31:0] q_v);
    bus_1.accumulated_data[k*64 +: 64] = {q_v, i_v};
  endtask

  task automatic pulse0(input logic [3:0] m);
    bus_0.start_trigger = m;
    @(negedge clk);
    bus_0.start_trigger = '0;
  endtask

  task automatic pulse1(input logic [3:0] m);
    bus_1.start_trigger = m;
    @(negedge clk);
    bus_1.start_trigger = '0;
  endtask

  task automatic drain0(input int budget);
    int n;
    n = 0;
    while ((er0.size() != 0 || ei0.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (er0.size() != 0 || ei0.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL dut0 drain: %0d results and %0d starts still outstanding, required 0",
               er0.size(), ei0.size());
      er0.delete();
      ei0.delete();
    end
  endtask

  task automatic drain1(input int budget);
    int n;
    n = 0;
    while ((er1.size() != 0 || ei1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (er1.size() != 0 || ei1.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL dut1 drain: %0d results and %0d starts still outstanding, required 0",
               er1.size(), ei1.size());
      er1.delete();
      ei1.delete();
    end
  endtask

  // Engine models: one reply entry consumed per nn_start.
  initial begin
    eng_t e;
    bus_0.nn_done = 1'b0; bus_0.nn_prob = '0; bus_0.nn_state = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_0.nn_start && eq0.size() > 0) begin
        e = eq0.pop_front();
        if (e.reply) begin
          repeat (e.dly) @(negedge clk);
          bus_0.nn_done = 1'b1; bus_0.nn_prob = e.prob; bus_0.nn_state = e.st;
          @(negedge clk);
          bus_0.nn_done = 1'b0; bus_0.nn_prob = '0; bus_0.nn_state = 1'b0;
        end
      end
    end
  end

  initial begin
    eng_t e;
    bus_1.nn_done = 1'b0; bus_1.nn_prob = '0; bus_1.nn_state = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_1.nn_start && eq1.size() > 0) begin
        e = eq1.pop_front();
        if (e.reply) begin
          repeat (e.dly) @(negedge clk);
          bus_1.nn_done = 1'b1; bus_1.nn_prob = e.prob; bus_1.nn_state = e.st;
          @(negedge clk);
          bus_1.nn_done = 1'b0; bus_1.nn_prob = '0; bus_1.nn_state = 1'b0;
        end
      end
    end
  end

  // Monitors
  always @(negedge clk) begin
    inp_t a;
    res_t r;
    if (bus_0.nn_start) begin
      if (ei0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut0 nn_start: got unexpected start at cycle %0d, required none", cyc);
      end else begin
        a = ei0.pop_front();
        chk("dut0 nn_input", bus_0.nn_input, a.inp);
        if (a.cyc >= 0) chk("dut0 nn_start cycle", cyc, a.cyc);
      end
    end
    if (bus_0.result_valid) begin
      if (er0.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut0 result_valid: got unexpected result ch %0d at cycle %0d, required none",
                 bus_0.result_channel, cyc);
      end else begin
        r = er0.pop_front();
        chk("dut0 result_channel", bus_0.result_channel, r.ch);
        chk("dut0 inference_prob", bus_0.inference_prob, r.prob);
        chk("dut0 inference_state", bus_0.inference_state, r.st);
        chk("dut0 result_timeout", bus_0.result_timeout, r.to);
        if (r.cyc >= 0) chk("dut0 result cycle", cyc, r.cyc);
      end
    end
  end

  always @(negedge clk) begin
    inp_t a;
    res_t r;
    if (bus_1.nn_start) begin
      if (ei1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut1 nn_start: got unexpected start at cycle %0d, required none", cyc);
      end else begin
        a = ei1.pop_front();
        chk("dut1 nn_input", bus_1.nn_input, a.inp);
        if (a.cyc >= 0) chk("dut1 nn_start cycle", cyc, a.cyc);
      end
    end
    if (bus_1.result_valid) begin
      if (er1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dut1 result_valid: got unexpected result ch %0d at cycle %0d, required none",
                 bus_1.result_channel, cyc);
      end else begin
        r = er1.pop_front();
        chk("dut1 result_channel", bus_1.result_channel, r.ch);
        chk("dut1 inference_prob", bus_1.inference_prob, r.prob);
        chk("dut1 inference_state", bus_1.inference_state, r.st);
        chk("dut1 result_timeout", bus_1.result_timeout, r.to);
        if (r.cyc >= 0) chk("dut1 result cycle", cyc, r.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_0 = 1'b1; rst_1 = 1'b1;
    bus_0.start_trigger = '0; bus_0.accumulated_data = '0;
    bus_1.start_trigger = '0; bus_1.accumulated_data = '0;
    repeat (3) @(negedge clk);
    rst_0 = 1'b0; rst_1 = 1'b0;

    chk("dut0 reset nn_start", bus_0.nn_start, 0);
    chk("dut0 reset result_valid", bus_0.result_valid, 0);
    chk("dut0 reset nn_input", bus_0.nn_input, 0);
    chk("dut0 reset overrun", bus_0.overrun, 0);
    chk("dut0 reset busy", bus_0.busy, 0);
    chk("dut1 reset overrun", bus_1.overrun, 0);
    chk("dut1 reset busy", bus_1.busy, 0);

    // Single channel: trigger ch2 in cycle 10.
    set0(2, 32'h0001_0000, 32'hFFFF_0000);
    ei0.push_back('{{18'h3FFFC, 18'h00004}, 13});
    eq0.push_back('{1'b1, 5, 18'h1F000, 1'b1});
    er0.push_back('{2, 18'h1F000, 1'b1, 1'b0, 19});
    wait_cyc(10);
    pulse0(4'b0100);
    chk("dut0 busy after capture", bus_0.busy, 1);
    drain0(60);

    rst_0 = 1'b1;
    @(negedge clk);
    rst_0 = 1'b0;
    chk("dut0 reset inference_prob", bus_0.inference_prob, 0);
    chk("dut0 reset result_channel", bus_0.result_channel, 0);
    chk("dut0 reset inference_state", bus_0.inference_state, 0);

    // Fairness: all four at once, ch0 re-triggered in its grant cycle.
    for (int k = 0; k < 4; k++) set0(k, 32'(k + 1) << 14, 32'h0);
    t = cyc;
    ei0.push_back('{36'd1, t + 3});
    ei0.push_back('{36'd2, -1});
    ei0.push_back('{36'd3, -1});
    ei0.push_back('{36'd4, -1});
    ei0.push_back('{36'd9, -1});
    eq0.push_back('{1'b1, 2, 18'h00011, 1'b0});
    eq0.push_back('{1'b1, 2, 18'h00022, 1'b1});
    eq0.push_back('{1'b1, 2, 18'h00033, 1'b0});
    eq0.push_back('{1'b1, 2, 18'h00044, 1'b1});
    eq0.push_back('{1'b1, 2, 18'h00055, 1'b1});
    er0.push_back('{0, 18'h00011, 1'b0, 1'b0, -1});
    er0.push_back('{1, 18'h00022, 1'b1, 1'b0, -1});
    er0.push_back('{2, 18'h00033, 1'b0, 1'b0, -1});
    er0.push_back('{3, 18'h00044, 1'b1, 1'b0, -1});
    er0.push_back('{0, 18'h00055, 1'b1, 1'b0, -1});
    pulse0(4'b1111);
    set0(0, 32'd9 << 14, 32'h0);
    pulse0(4'b0001);
    drain0(150);
    chk("dut0 collision overrun", bus_0.overrun, 0);
    chk("dut0 idle busy", bus_0.busy, 0);

    // Reset while waiting on the engine; its late reply must be ignored.
    set0(1, 32'h0000_4000, 32'h0);
    t = cyc;
    ei0.push_back('{36'd1, t + 3});
    eq0.push_back('{1'b1, 12, 18'h3FFFF, 1'b1});
    pulse0(4'b0010);
    wait_cyc(t + 6);
    rst_0 = 1'b1;
    @(negedge clk);
    rst_0 = 1'b0;
    chk("dut0 mid-wait reset busy", bus_0.busy, 0);
    chk("dut0 mid-wait reset overrun", bus_0.overrun, 0);
    wait_cyc(t + 20);
    chk("dut0 late done ignored prob", bus_0.inference_prob, 0);
    chk("dut0 late done ignored busy", bus_0.busy, 0);
    set0(0, 32'd5 << 14, 32'h0);
    set0(3, 32'd3 << 14, 32'h0);
    ei0.push_back('{36'd5, -1});
    ei0.push_back('{36'd3, -1});
    eq0.push_back('{1'b1, 1, 18'h0AAAA, 1'b0});
    eq0.push_back('{1'b1, 1, 18'h15555, 1'b1});
    er0.push_back('{0, 18'h0AAAA, 1'b0, 1'b0, -1});
    er0.push_back('{3, 18'h15555, 1'b1, 1'b0, -1});
    pulse0(4'b1001);
    drain0(60);

    // Saturation on ch0 while ch1 overruns behind it.
    set1(0, 32'h7FFF_FFFF, 32'h8000_0000);
    t = cyc;
    ei1.push_back('{{18'h20000, 18'h1FFFF}, t + 3});
    eq1.push_back('{1'b1, 8, 18'h12345, 1'b0});
    er1.push_back('{0, 18'h12345, 1'b0, 1'b0, t + 12});
    pulse1(4'b0001);
    set1(1, 32'd5, 32'h0);
    ei1.push_back('{36'd5, -1});
    eq1.push_back('{1'b1, 3, 18'h2AAAA, 1'b1});
    er1.push_back('{1, 18'h2AAAA, 1'b1, 1'b0, -1});
    wait_cyc(t + 5);
    pulse1(4'b0010);
    set1(1, 32'd7, 32'h0);
    pulse1(4'b0010);
    chk("dut1 overrun set", bus_1.overrun, 4'b0010);
    drain1(80);
    chk("dut1 overrun sticky", bus_1.overrun, 4'b0010);

    // Engine silent on ch2 -> watchdog result, then ch3 granted.
    set1(2, 32'd3, 32'h0);
    set1(3, 32'hFFFF_FFFD, 32'h0);
    t = cyc;
    ei1.push_back('{36'd3, t + 3});
    ei1.push_back('{{18'h00000, 18'h3FFFD}, t + 26});
    eq1.push_back('{1'b0, 0, 18'h0, 1'b0});
    eq1.push_back('{1'b1, 2, 18'h00777, 1'b1});
    er1.push_back('{2, 18'h00000, 1'b0, 1'b1, t + 24});
    er1.push_back('{3, 18'h00777, 1'b1, 1'b0, -1});
    pulse1(4'b1100);
    drain1(100);
    chk("dut1 overrun still sticky", bus_1.overrun, 4'b0010);

    rst_1 = 1'b1;
    @(negedge clk);
    rst_1 = 1'b0;
    chk("dut1 overrun cleared by rst", bus_1.overrun, 0);
    chk("dut1 busy after rst", bus_1.busy, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ml_multi_interface.md
Name: ml_multi_interface

Overview:
- Parametrised, multi-channel front end for the shared neural-network inference engine.
- Captures accumulated I/Q readout words from N_CH qubit channels and normalises each by arithmetic shift with saturation.
- Arbitrates channels round-robin onto a single inference engine and returns each result tagged with its channel index.
- Adds per-channel overrun detection and an engine-timeout watchdog.

Parameters:
- N_CH, 4, number of readout channels (1..16).
- IN_W, 32, signed width of each accumulated I or Q component.
- OUT_W, 18, signed width of each normalised component and of inference_prob.
- SHIFT, 14, arithmetic right-shift applied before saturation.
- TIMEOUT, 1023, maximum cycles to wait for nn_done after nn_start.
- CH_W, max(1,$clog2(N_CH)), channel index width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start_trigger  in  N_CH  per-channel one-cycle strobe; accumulated data for that channel is valid in the same cycle.
- accumulated_data  in  N_CH*2*IN_W  channel k = bits [k*2*IN_W +: 2*IN_W]; Q in the upper IN_W bits, I in the lower IN_W bits.
- nn_start  out  1  one-cycle start pulse to the engine.
- nn_input  out  2*OUT_W  normalised {Q,I}; held stable from nn_start until the next NORM cycle.
- nn_done  in  1  engine result strobe.
- nn_prob  in  OUT_W  engine probability, valid with nn_done.
- nn_state  in  1  engine state decision, valid with nn_done.
- result_valid  out  1  one-cycle result strobe.
- result_channel  out  CH_W  channel of the current result.
- inference_prob  out  OUT_W  probability, registered.
- inference_state  out  1  state, registered.
- result_timeout  out  1  set with result_valid when the engine timed out.
- overrun  out  N_CH  sticky per-channel overrun flags.
- busy  out  1  high when FSM is not in IDLE or any channel is pending.

Behaviour:
- Reset (rst high at a clock edge) clears all outputs, pending bits, capture registers, overrun, nn_input and the timeout counter. The FSM goes to IDLE and the round-robin pointer goes to 0. Reset takes precedence over every other event. A reset issued during WAIT abandons the job with no result_valid; a late nn_done after reset is ignored.
- Capture: start_trigger[k] with pending[k]=0 latches channel k data into capture register k and sets pending[k] on the same edge.
- Overrun: start_trigger[k] with pending[k]=1 sets overrun[k] and discards the new data; the old capture is kept. overrun bits clear only on rst.
- Grant/trigger collision: if channel k is granted (pending cleared) and start_trigger[k] is high in the same cycle, the new data is captured, pending[k] stays 1, and no overrun is flagged. The granted data was already read.
- FSM states:
  - IDLE: if any pending bit is set, pick the first pending channel at or after the pointer, modulo N_CH. Store it as sel, clear pending[sel], set pointer to sel+1 mod N_CH, go to NORM.
  - NORM: register nn_input = {sat(Q>>>SHIFT), sat(I>>>SHIFT)}. sat clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Go to START.
  - START: nn_start=1 for this cycle only. Clear the timeout counter. Go to WAIT.
  - WAIT: the counter increments each cycle.
    - On nn_done: register nn_prob/nn_state into inference_prob/inference_state, set result_channel=sel, pulse result_valid next cycle with result_timeout=0, go to IDLE.
    - If the counter reaches TIMEOUT without nn_done: pulse result_valid with result_timeout=1 and inference_prob=0, inference_state=0, go to IDLE.
- nn_done outside WAIT is ignored.
- Latency: start_trigger in cycle c with the engine free gives nn_start in cycle c+3. nn_done in cycle d gives result_valid in cycle d+1.
- Only one job is outstanding at a time. The earliest re-grant is the cycle after result_valid.
- inference_prob, inference_state and result_channel hold their values until the next result.

Test Plan:
- Single channel: N_CH=4; trigger ch2 with I=0x0001_0000, Q=0xFFFF_0000 in cycle 10; engine replies nn_done 5 cycles after nn_start with prob=0x1F000, state=1 -> nn_start in cycle 13, nn_input={-4,4}, result_valid in cycle 19 with channel 2, prob 0x1F000, state 1, timeout 0.
- Fairness: all four channels triggered in the same cycle, then ch0 re-triggered immediately after its grant -> result order 0,1,2,3,0.
- Overrun: trigger ch1 twice while pending, with I=5 then I=7 (SHIFT=0) -> overrun=4'b0010, the processed I equals 5, and overrun stays set until rst.
- Saturation: I=0x7FFF_FFFF, Q=0x8000_0000, SHIFT=0 -> nn_input I=0x1FFFF, Q=0x20000.
- Timeout: TIMEOUT=20, engine never responds -> result_valid exactly 20 cycles after the WAIT entry, with result_timeout=1 and prob=0. The next pending channel is then granted.
- Reset mid-WAIT: assert rst for 1 cycle while in WAIT, then nn_done arrives -> no result_valid, overrun=0, busy=0, pointer=0.
